// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin 8:1 mux arbiter.
package mux_rr_arbiter_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned SEL_W = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return NREQ'(1) << i;
  endfunction

endpackage

// File: rtl/eight_to_one_mux.sv
// Legacy single-bit 8:1 multiplexer, select {s2,s1,s0}.
module eight_to_one_mux (
  input  logic [7:0] d,
  input  logic [2:0] s,
  output logic       y
);

  assign y = d[s];

endmodule

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request searching ptr, ptr+1, .. ptr+7 mod 8.
module rr_priority_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [SEL_W-1:0]  off;

  // Rotate so that bit 0 of rot is the requester at ptr.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NREQ-1:0];

  always_comb begin
    any = 1'b0;
    off = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        off = i[SEL_W-1:0];
      end
    end
  end

  assign idx = ptr + off;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a shared 8:1 single-bit mux with bounded hold and registered output.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int unsigned         HOLD_W   = 4,
  parameter logic [HOLD_W-1:0]   MAX_HOLD = 4'd15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  din,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             dout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [0:0]        state;
  logic [SEL_W-1:0]  ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic              pick_any;
  logic [SEL_W-1:0]  pick_idx;
  logic [SEL_W-1:0]  mux_sel;
  logic              mux_y;
  logic              grant_exit;

  rr_priority_pick u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Mux is steered by the next-state select so dout registers the winner's bit on entry.
  assign mux_sel = (state == ST_IDLE) ? pick_idx : sel;

  eight_to_one_mux u_mux (
    .d (din),
    .s (mux_sel),
    .y (mux_y)
  );

  assign grant_exit = !req[sel] || ((hold_cnt == HOLD_LAST) && ((req & ~gnt) != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      sel      <= '0;
      valid    <= 1'b0;
      dout     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state    <= ST_GRANT;
            gnt      <= onehot(pick_idx);
            sel      <= pick_idx;
            valid    <= 1'b1;
            dout     <= mux_y;
            hold_cnt <= '0;
          end
        end
        default: begin
          if (grant_exit) begin
            state <= ST_IDLE;
            gnt   <= '0;
            valid <= 1'b0;
            dout  <= 1'b0;
            ptr   <= sel + 3'd1;
          end else begin
            dout <= mux_y;
            if (hold_cnt != HOLD_LAST)
              hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with MAX_HOLD=4 and a per-cycle grant invariant monitor.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] din;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;
  logic       dout;

  int vec_cnt = 0;
  int err_cnt = 0;

  mux_rr_arbiter #(.HOLD_W(4), .MAX_HOLD(4'd4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .din   (din),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] idx_of(input logic [7:0] g);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  // Invariants: grant one-hot-or-zero, valid mirrors grant, sel matches grant index.
  always @(negedge clk) begin
    vec_cnt++;
    if (((gnt & (gnt - 8'd1)) != 8'd0) || (valid !== (gnt != 8'd0)) ||
        (valid && (sel !== idx_of(gnt)))) begin
      err_cnt++;
      $display("FAIL invariant: gnt=%h sel=%0d valid=%b", gnt, sel, valid);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic expect_out(input string name, input logic [7:0] eg, input logic [2:0] es,
                            input logic ev, input logic ed);
    vec_cnt++;
    if (gnt !== eg || sel !== es || valid !== ev || dout !== ed) begin
      err_cnt++;
      $display("FAIL %s: got gnt=%h sel=%0d valid=%b dout=%b, want gnt=%h sel=%0d valid=%b dout=%b",
               name, gnt, sel, valid, dout, eg, es, ev, ed);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 8'h00; din = 8'h00;
    #3;
    expect_out("reset_initial", 8'h00, 3'd0, 1'b0, 1'b0);
    step(2);
    rst_n = 1'b1;
    req = 8'hFF; din = 8'hFF;
    step(1);
    expect_out("reset_first_grant", 8'h01, 3'd0, 1'b1, 1'b1);
    step(5);
    expect_out("reset_second_grant", 8'h02, 3'd1, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    expect_out("reset_async_clear", 8'h00, 3'd0, 1'b0, 1'b0);
    step(1);
    req = 8'h00; din = 8'h00;
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_single();
    req = 8'h08; din = 8'h08;
    step(1);
    expect_out("single_grant_d1", 8'h08, 3'd3, 1'b1, 1'b1);
    din = 8'hF7;
    step(1);
    expect_out("single_track_d0", 8'h08, 3'd3, 1'b1, 1'b0);
    din = 8'h08;
    step(1);
    expect_out("single_track_d1", 8'h08, 3'd3, 1'b1, 1'b1);
    req = 8'h00;
    step(1);
    expect_out("single_release", 8'h00, 3'd3, 1'b0, 1'b0);
    step(1);
    expect_out("single_idle_hold", 8'h00, 3'd3, 1'b0, 1'b0);
  endtask

  task automatic test_rotation();
    logic [2:0] k;
    pulse_reset();
    req = 8'hFF; din = 8'h55;
    step(1);
    for (int g = 0; g < 9; g++) begin
      k = 3'(g);
      for (int c = 0; c < 4; c++) begin
        expect_out($sformatf("rot_g%0d_c%0d", g, c), 8'h01 << k, k, 1'b1, din[k]);
        step(1);
      end
      expect_out($sformatf("rot_gap%0d", g), 8'h00, k, 1'b0, 1'b0);
      if (g == 8) req = 8'h00;
      step(1);
    end
    expect_out("rot_idle", 8'h00, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    pulse_reset();
    din = 8'h00;
    req = 8'h02;
    step(1);
    req = 8'h00;
    step(1);
    req = 8'h80;
    step(1);
    expect_out("wrap_grant7", 8'h80, 3'd7, 1'b1, 1'b0);
    req = 8'h00;
    step(1);
    expect_out("wrap_release7", 8'h00, 3'd7, 1'b0, 1'b0);
    req = 8'h81;
    step(1);
    expect_out("wrap_grant0", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h80;
    step(1);
    expect_out("wrap_gap", 8'h00, 3'd0, 1'b0, 1'b0);
    step(1);
    expect_out("wrap_grant7_again", 8'h80, 3'd7, 1'b1, 1'b0);
    req = 8'h00;
    step(2);
  endtask

  task automatic test_lone();
    int waited;
    pulse_reset();
    req = 8'h20; din = 8'h20;
    step(1);
    expect_out("lone_grant", 8'h20, 3'd5, 1'b1, 1'b1);
    for (int c = 0; c < 40; c++) begin
      step(1);
      expect_out($sformatf("lone_hold%0d", c), 8'h20, 3'd5, 1'b1, 1'b1);
    end
    req = 8'h21;
    waited = 0;
    do begin
      step(1);
      waited++;
    end while (gnt != 8'h00 && waited < 4);
    vec_cnt++;
    if (gnt !== 8'h00) begin
      err_cnt++;
      $display("FAIL lone_forced_rotation: got gnt=%h after %0d cycles, want 00 within 4", gnt, waited);
    end
    step(1);
    expect_out("lone_handoff", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    step(2);
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    din = 8'h00;
    req = 8'h08;
    step(1);
    expect_out("simul_grant3", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h10;
    step(1);
    expect_out("simul_gap", 8'h00, 3'd3, 1'b0, 1'b0);
    step(1);
    expect_out("simul_grant4", 8'h10, 3'd4, 1'b1, 1'b0);
    req = 8'h00;
    step(2);
  endtask

  task automatic test_post_reset();
    pulse_reset();
    din = 8'h00;
    req = 8'h02;
    step(1);
    req = 8'h00;
    step(1);
    req = 8'h20;
    step(1);
    expect_out("postrst_grant5", 8'h20, 3'd5, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_out("postrst_clear", 8'h00, 3'd0, 1'b0, 1'b0);
    step(1);
    rst_n = 1'b1;
    req = 8'h06;
    step(1);
    expect_out("postrst_ptr0", 8'h02, 3'd1, 1'b1, 1'b0);
    req = 8'h00;
    step(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_lone();
    test_simultaneous();
    test_post_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
